// File: rtl/axilite_gpio_in.sv
// axilite_gpio_in: AXI4-Lite GPIO input block with synchronizer, edge-detect pending bits and level interrupt
module axilite_gpio_in #(
  parameter int NUM_GPIO   = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  input  logic [NUM_GPIO-1:0]   gpio_i,
  output logic                  irq_o,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t w_state;
  r_state_t r_state;
  logic up, w_go, w_err, r_err, unused;
  logic [NUM_GPIO-1:0] sync1, sync2, prev, irq_en, pending, edge_sel, hit, wmask, wbits, clr;
  logic [31:0] bmask, r_val;
  assign s_axi_awready = up && w_state == W_IDLE && s_axi_awvalid && s_axi_wvalid;
  assign s_axi_wready = s_axi_awready;
  assign s_axi_arready = up && r_state == R_IDLE;
  assign s_axi_bvalid = w_state == W_RESP;
  assign s_axi_rvalid = r_state == R_DATA;
  assign w_go = s_axi_awready;
  assign w_err = |s_axi_awaddr[ADDR_WIDTH-1:4] || s_axi_awaddr[3:2] == 2'd0;
  assign r_err = |s_axi_araddr[ADDR_WIDTH-1:4];
  assign bmask = {{8{s_axi_wstrb[3]}}, {8{s_axi_wstrb[2]}}, {8{s_axi_wstrb[1]}}, {8{s_axi_wstrb[0]}}};
  assign wmask = bmask[NUM_GPIO-1:0];
  assign wbits = s_axi_wdata[NUM_GPIO-1:0];
  assign hit = (edge_sel & sync2 & ~prev) | (~edge_sel & ~sync2 & prev);
  assign clr = (w_go && !w_err && s_axi_awaddr[3:2] == 2'd2) ? wbits & wmask : '0;
  assign unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata, bmask};
  always_comb
    r_val = r_err ? 32'd0 :
            s_axi_araddr[3:2] == 2'd0 ? 32'(sync2) :
            s_axi_araddr[3:2] == 2'd1 ? 32'(irq_en) :
            s_axi_araddr[3:2] == 2'd2 ? 32'(pending) : 32'(edge_sel);
  always_ff @(posedge clock_i or negedge reset_ni)
    if (!reset_ni) begin
      up <= 1'b0;
      sync1 <= '0;
      sync2 <= '0;
      prev <= '0;
      irq_en <= '0;
      pending <= '0;
      edge_sel <= '0;
      irq_o <= 1'b0;
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      s_axi_bresp <= 2'b00;
      s_axi_rresp <= 2'b00;
      s_axi_rdata <= '0;
    end else begin
      up <= 1'b1;
      sync1 <= gpio_i;
      sync2 <= sync1;
      prev <= sync2;
      pending <= (pending & ~clr) | hit;
      irq_o <= |(pending & irq_en);
      if (w_go && !w_err && s_axi_awaddr[3:2] == 2'd1) irq_en <= (irq_en & ~wmask) | (wbits & wmask);
      if (w_go && !w_err && s_axi_awaddr[3:2] == 2'd3) edge_sel <= (edge_sel & ~wmask) | (wbits & wmask);
      if (w_go) begin
        w_state <= W_RESP;
        s_axi_bresp <= w_err ? 2'b10 : 2'b00;
      end else if (s_axi_bvalid && s_axi_bready) w_state <= W_IDLE;
      if (s_axi_arready && s_axi_arvalid) begin
        r_state <= R_DATA;
        s_axi_rdata <= r_val;
        s_axi_rresp <= r_err ? 2'b10 : 2'b00;
      end else if (s_axi_rvalid && s_axi_rready) r_state <= R_IDLE;
    end
endmodule

// File: doc/axilite_gpio_in.md
AXILITE_GPIO_IN -- requirements
Module: axilite_gpio_in

Interface
REQ-001 SHALL have parameter NUM_GPIO, default 16, number of input pins (1..32).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, AXI address width; only addr[3:2] decoded.
REQ-003 SHALL have port clock_i, input, 1, system clock; all logic on rising edge.
REQ-004 SHALL have port reset_ni, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port gpio_i, input, NUM_GPIO, asynchronous external pins.
REQ-006 SHALL have port irq_o, input-to-PLIC interrupt output, 1, level-high.
REQ-007 SHALL have ports s_axi_awaddr in ADDR_WIDTH, s_axi_awvalid in 1, s_axi_awready out 1 (write address).
REQ-008 SHALL have ports s_axi_wdata in 32, s_axi_wstrb in 4, s_axi_wvalid in 1, s_axi_wready out 1 (write data).
REQ-009 SHALL have ports s_axi_bresp out 2, s_axi_bvalid out 1, s_axi_bready in 1 (write response).
REQ-010 SHALL have ports s_axi_araddr in ADDR_WIDTH, s_axi_arvalid in 1, s_axi_arready out 1 (read address).
REQ-011 SHALL have ports s_axi_rdata out 32, s_axi_rresp out 2, s_axi_rvalid out 1, s_axi_rready in 1 (read data).

Function
REQ-012 SHALL be an AXI4-Lite responder on the crossbar; prot signals are not present.
REQ-013 SHALL pass gpio_i through a 2-flop synchronizer, then a third flop (prev) for edge detect; input-to-DATA latency is 2 cycles.
REQ-014 SHALL map registers: 0x0 DATA (RO, synced pins), 0x4 IRQ_EN (RW), 0x8 PENDING (RW1C), 0xC EDGE_SEL (RW, 1=rising, 0=falling).
REQ-015 SHALL zero-extend NUM_GPIO-wide registers to 32 bits on read; writes to bits >= NUM_GPIO are ignored.
REQ-016 SHALL set PENDING[i] on a selected edge of synced bit i, regardless of IRQ_EN[i].
REQ-017 SHALL, on simultaneous edge-set and W1C clear of the same bit in one cycle, leave the bit set (set wins).
REQ-018 SHALL drive irq_o registered = |(PENDING & IRQ_EN), one cycle after PENDING/IRQ_EN update.
REQ-019 SHALL use write FSM states W_IDLE, W_RESP: in W_IDLE assert awready and wready only when both awvalid and wvalid are high, accept both in the same cycle, perform the write, go to W_RESP.
REQ-020 SHALL in W_RESP hold bvalid high with bresp stable until bready; return to W_IDLE on bvalid&&bready; no new write accepted while in W_RESP.
REQ-021 SHALL honour wstrb per byte on IRQ_EN, EDGE_SEL, PENDING; a PENDING byte with strobe low is not cleared.
REQ-022 SHALL use read FSM states R_IDLE, R_DATA: in R_IDLE arready=1; on arvalid capture data into rdata, go to R_DATA; rvalid asserted the following cycle.
REQ-023 SHALL in R_DATA hold rvalid, rdata, rresp stable until rready; arready=0 in R_DATA.
REQ-024 SHALL respond to addresses with addr[ADDR_WIDTH-1:4] nonzero, or to writes to DATA, with resp=2'b10 (SLVERR), no state change, rdata=0; otherwise resp=2'b00.
REQ-025 SHALL allow read and write channels to operate concurrently and independently.
REQ-026 SHALL not generate an edge on the first synchronized sample after reset (prev initialised equal via reset to 0; a pin high at reset gives one rising edge, documented behaviour).

Reset
REQ-027 SHALL on reset_ni low immediately clear: IRQ_EN, PENDING, EDGE_SEL, synchronizer and prev flops, irq_o, bvalid, rvalid, rdata, bresp, rresp to 0; awready, wready to 0; arready to 0; FSMs to W_IDLE/R_IDLE.
REQ-028 SHALL abort any in-flight transaction on reset mid-handshake; no response is issued for it after reset release.
REQ-029 SHALL assert arready (R_IDLE) from the first clock edge after reset_ni rises.

Verification
REQ-030 Write 0x4=0x0001, 0xC=0x0001, drive gpio_i[0] 0->1 -> PENDING=0x0001 after 3 cycles, irq_o=1 one cycle later; write 0x8=0x0001 -> irq_o=0.
REQ-031 EDGE_SEL=0, IRQ_EN=0, gpio_i[5] 1->0 -> PENDING[5]=1, irq_o stays 0; set IRQ_EN[5] -> irq_o=1.
REQ-032 Read 0x10 -> rresp=2'b10, rdata=0; write DATA 0x0 -> bresp=2'b10, registers unchanged.
REQ-033 Hold bready=0 for 5 cycles after write -> bvalid stays 1, awready/wready stay 0; second write accepted only after handshake.
REQ-034 Edge on gpio_i[2] in same cycle as W1C of bit 2 -> PENDING[2]=1 afterwards.
REQ-035 Assert reset_ni low while rvalid=1 and PENDING=0xFFFF -> rvalid=0, PENDING=0, irq_o=0 immediately, no stale R beat after release.
